// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencer for the 5-stage RV32IM core
// Handles load-use bubbles, branch flushes, M-unit EX occupancy and memory freeze.
module hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        MEM_BUSYWAIT,
  input  logic        MEM_READ_EN_IDEX,
  input  logic [4:0]  REG_WRITE_ADDR_IDEX,
  input  logic [4:0]  ADDR_1_ID,
  input  logic [4:0]  ADDR_2_ID,
  input  logic        USES_RS1_ID,
  input  logic        USES_RS2_ID,
  input  logic        BRANCH_TAKEN_EX,
  input  logic        MULDIV_VALID_EX,
  input  logic        MULDIV_IS_DIV_EX,
  output logic        PC_STALL,
  output logic        IFID_STALL,
  output logic        IFID_RESET,
  output logic        IDEX_STALL,
  output logic        IDEX_RESET,
  output logic        EXMEM_RESET,
  output logic        MULDIV_START,
  output logic        MULDIV_DONE,
  output logic [31:0] PERF_STALL_CNT,
  output logic [15:0] PERF_FLUSH_CNT
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // The start cycle and the done cycle are not counted, hence LAT-2.
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 2);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             load_use;
  logic             flush;
  logic [31:0]      stall_cnt;
  logic [15:0]      flush_cnt;

  assign load_use = MEM_READ_EN_IDEX
                 && (REG_WRITE_ADDR_IDEX != 5'd0)
                 && ((USES_RS1_ID && (ADDR_1_ID == REG_WRITE_ADDR_IDEX))
                  || (USES_RS2_ID && (ADDR_2_ID == REG_WRITE_ADDR_IDEX)));

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    flush        = 1'b0;
    PC_STALL     = 1'b0;
    IFID_STALL   = 1'b0;
    IFID_RESET   = 1'b0;
    IDEX_STALL   = 1'b0;
    IDEX_RESET   = 1'b0;
    EXMEM_RESET  = 1'b0;
    MULDIV_START = 1'b0;
    MULDIV_DONE  = 1'b0;

    if (!RESET_N) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else if (MEM_BUSYWAIT) begin
      // Whole pipeline frozen; pending branch/M op is re-evaluated afterwards.
      PC_STALL   = 1'b1;
      IFID_STALL = 1'b1;
      IDEX_STALL = 1'b1;
    end else if (state == MD_BUSY) begin
      if (cnt != '0) begin
        PC_STALL    = 1'b1;
        IFID_STALL  = 1'b1;
        IDEX_STALL  = 1'b1;
        EXMEM_RESET = 1'b1;
        cnt_nxt     = cnt - 1'b1;
      end else begin
        MULDIV_DONE = 1'b1;
        state_nxt   = RUN;
      end
    end else if (MULDIV_VALID_EX) begin
      MULDIV_START = 1'b1;
      PC_STALL     = 1'b1;
      IFID_STALL   = 1'b1;
      IDEX_STALL   = 1'b1;
      EXMEM_RESET  = 1'b1;
      cnt_nxt      = MULDIV_IS_DIV_EX ? DIV_CNT_INIT : MUL_CNT_INIT;
      state_nxt    = MD_BUSY;
    end else if (BRANCH_TAKEN_EX) begin
      IFID_RESET = 1'b1;
      IDEX_RESET = 1'b1;
      flush      = 1'b1;
    end else if (load_use) begin
      PC_STALL   = 1'b1;
      IFID_STALL = 1'b1;
      IDEX_RESET = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= RUN;
      cnt       <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (PC_STALL) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end

  assign PERF_STALL_CNT = stall_cnt;
  assign PERF_FLUSH_CNT = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;
  localparam int CNT_W   = 6;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        MEM_BUSYWAIT, MEM_READ_EN_IDEX, USES_RS1_ID, USES_RS2_ID;
  logic        BRANCH_TAKEN_EX, MULDIV_VALID_EX, MULDIV_IS_DIV_EX;
  logic [4:0]  REG_WRITE_ADDR_IDEX, ADDR_1_ID, ADDR_2_ID;
  logic        PC_STALL, IFID_STALL, IFID_RESET, IDEX_STALL, IDEX_RESET;
  logic        EXMEM_RESET, MULDIV_START, MULDIV_DONE;
  logic [31:0] PERF_STALL_CNT;
  logic [15:0] PERF_FLUSH_CNT;

  int checks = 0;
  int failures = 0;

  // Reference model: remaining EX cycles of the M op (0 = EX free).
  int          md_left = 0;
  logic [31:0] m_stall = '0;
  logic [15:0] m_flush = '0;

  hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .MEM_READ_EN_IDEX(MEM_READ_EN_IDEX), .REG_WRITE_ADDR_IDEX(REG_WRITE_ADDR_IDEX),
    .ADDR_1_ID(ADDR_1_ID), .ADDR_2_ID(ADDR_2_ID), .USES_RS1_ID(USES_RS1_ID),
    .USES_RS2_ID(USES_RS2_ID), .BRANCH_TAKEN_EX(BRANCH_TAKEN_EX),
    .MULDIV_VALID_EX(MULDIV_VALID_EX), .MULDIV_IS_DIV_EX(MULDIV_IS_DIV_EX),
    .PC_STALL(PC_STALL), .IFID_STALL(IFID_STALL), .IFID_RESET(IFID_RESET),
    .IDEX_STALL(IDEX_STALL), .IDEX_RESET(IDEX_RESET), .EXMEM_RESET(EXMEM_RESET),
    .MULDIV_START(MULDIV_START), .MULDIV_DONE(MULDIV_DONE),
    .PERF_STALL_CNT(PERF_STALL_CNT), .PERF_FLUSH_CNT(PERF_FLUSH_CNT)
  );

  always #5 CLK = ~CLK;

  // Bit order: pc_stall ifid_stall ifid_reset idex_stall idex_reset exmem_reset start done
  function automatic logic [7:0] dut_out();
    return {PC_STALL, IFID_STALL, IFID_RESET, IDEX_STALL, IDEX_RESET,
            EXMEM_RESET, MULDIV_START, MULDIV_DONE};
  endfunction

  function automatic logic [7:0] model_out();
    logic lu;
    lu = MEM_READ_EN_IDEX && REG_WRITE_ADDR_IDEX != 0 &&
         ((USES_RS1_ID && ADDR_1_ID == REG_WRITE_ADDR_IDEX) ||
          (USES_RS2_ID && ADDR_2_ID == REG_WRITE_ADDR_IDEX));
    if (!RESET_N)            return 8'b0000_0000;
    if (MEM_BUSYWAIT)        return 8'b1101_0000;
    if (md_left > 1)         return 8'b1101_0100;
    if (md_left == 1)        return 8'b0000_0001;
    if (MULDIV_VALID_EX)     return 8'b1101_0110;
    if (BRANCH_TAKEN_EX)     return 8'b0010_1000;
    if (lu)                  return 8'b1100_1000;
    return 8'b0000_0000;
  endfunction

  task automatic clear_inputs();
    MEM_BUSYWAIT = 0; MEM_READ_EN_IDEX = 0; USES_RS1_ID = 0; USES_RS2_ID = 0;
    BRANCH_TAKEN_EX = 0; MULDIV_VALID_EX = 0; MULDIV_IS_DIV_EX = 0;
    REG_WRITE_ADDR_IDEX = 0; ADDR_1_ID = 0; ADDR_2_ID = 0;
  endtask

  // One clock: check outputs and counters at the falling edge, advance model at the rising edge.
  task automatic cycle(output logic [7:0] got);
    logic [7:0] exp;
    @(negedge CLK);
    exp = model_out();
    got = dut_out();
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL outputs t=%0t got=%b expected=%b", $time, got, exp);
    end
    checks++;
    if (PERF_STALL_CNT !== m_stall || PERF_FLUSH_CNT !== m_flush) begin
      failures++;
      $display("FAIL perf_counters t=%0t got=%0d/%0d expected=%0d/%0d",
               $time, PERF_STALL_CNT, PERF_FLUSH_CNT, m_stall, m_flush);
    end
    @(posedge CLK);
    if (!RESET_N) begin
      md_left = 0; m_stall = '0; m_flush = '0;
    end else begin
      if (exp[7]) m_stall = m_stall + 1;
      if (!MEM_BUSYWAIT) begin
        if (md_left > 0)          md_left = md_left - 1;
        else if (MULDIV_VALID_EX) md_left = (MULDIV_IS_DIV_EX ? DIV_LAT : MUL_LAT) - 1;
        else if (BRANCH_TAKEN_EX) m_flush = m_flush + 1;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    logic [7:0] g;
    clear_inputs();
    RESET_N = 0;
    md_left = 0; m_stall = '0; m_flush = '0;
    cycle(g);
    RESET_N = 1;
  endtask

  task automatic test_reset();
    logic [7:0] g;
    RESET_N = 0;
    clear_inputs();
    MEM_BUSYWAIT = 1; MULDIV_VALID_EX = 1; BRANCH_TAKEN_EX = 1;
    MEM_READ_EN_IDEX = 1; REG_WRITE_ADDR_IDEX = 5; ADDR_1_ID = 5; USES_RS1_ID = 1;
    #1;
    checks++;
    if (dut_out() !== 8'h00 || PERF_STALL_CNT !== 0 || PERF_FLUSH_CNT !== 0) begin
      failures++;
      $display("FAIL reset_state got=%b/%0d/%0d expected=00000000/0/0",
               dut_out(), PERF_STALL_CNT, PERF_FLUSH_CNT);
    end
    cycle(g);
    cycle(g);
    clear_inputs();
    RESET_N = 1;
    cycle(g);
  endtask

  task automatic test_load_use();
    logic [7:0] g;
    do_reset();
    MEM_READ_EN_IDEX = 1; REG_WRITE_ADDR_IDEX = 5; ADDR_2_ID = 5; USES_RS2_ID = 1;
    ADDR_1_ID = 7; USES_RS1_ID = 1;
    cycle(g);
    checks++;
    if (g !== 8'b1100_1000) begin
      failures++; $display("FAIL load_use_bubble got=%b expected=11001000", g);
    end
    clear_inputs();
    cycle(g);
    checks++;
    if (g !== 8'h00 || PERF_STALL_CNT !== 32'd1) begin
      failures++; $display("FAIL load_use_clear got=%b/%0d expected=00000000/1", g, PERF_STALL_CNT);
    end
    MEM_READ_EN_IDEX = 1; REG_WRITE_ADDR_IDEX = 0; ADDR_1_ID = 0; ADDR_2_ID = 0;
    USES_RS1_ID = 1; USES_RS2_ID = 1;
    cycle(g);
    checks++;
    if (g !== 8'h00) begin
      failures++; $display("FAIL load_use_x0 got=%b expected=00000000", g);
    end
    clear_inputs();
  endtask

  task automatic test_branch_load_use();
    logic [7:0] g;
    do_reset();
    MEM_READ_EN_IDEX = 1; REG_WRITE_ADDR_IDEX = 9; ADDR_1_ID = 9; USES_RS1_ID = 1;
    BRANCH_TAKEN_EX = 1;
    cycle(g);
    checks++;
    if (g !== 8'b0010_1000) begin
      failures++; $display("FAIL branch_over_load_use got=%b expected=00101000", g);
    end
    clear_inputs();
    cycle(g);
    checks++;
    if (PERF_FLUSH_CNT !== 16'd1 || PERF_STALL_CNT !== 32'd0) begin
      failures++; $display("FAIL branch_counters got=%0d/%0d expected=1/0", PERF_FLUSH_CNT, PERF_STALL_CNT);
    end
  endtask

  task automatic test_muldiv(input logic is_div, input int lat);
    logic [7:0] g;
    logic [7:0] exp;
    do_reset();
    MULDIV_VALID_EX = 1; MULDIV_IS_DIV_EX = is_div;
    for (int k = 0; k < lat; k++) begin
      cycle(g);
      exp = (k < lat - 1) ? (8'b1101_0100 | ((k == 0) ? 8'b10 : 8'b0)) : 8'b0000_0001;
      checks++;
      if (g !== exp) begin
        failures++; $display("FAIL muldiv_seq div=%0d cycle=%0d got=%b expected=%b", is_div, k, g, exp);
      end
      MULDIV_VALID_EX = 0;
      BRANCH_TAKEN_EX = $urandom_range(0, 1);
      MEM_READ_EN_IDEX = 1; REG_WRITE_ADDR_IDEX = 3; ADDR_1_ID = 3; USES_RS1_ID = 1;
    end
    clear_inputs();
    cycle(g);
    checks++;
    if (PERF_STALL_CNT !== 32'(lat - 1) || PERF_FLUSH_CNT !== 16'd0) begin
      failures++;
      $display("FAIL muldiv_counters div=%0d got=%0d/%0d expected=%0d/0", is_div,
               PERF_STALL_CNT, PERF_FLUSH_CNT, lat - 1);
    end
  endtask

  task automatic test_busywait_div();
    logic [7:0] g;
    int done_at = -1;
    do_reset();
    MULDIV_VALID_EX = 1; MULDIV_IS_DIV_EX = 1;
    for (int c = 0; c < 60 && done_at < 0; c++) begin
      MEM_BUSYWAIT = (c >= 10 && c < 15);
      cycle(g);
      if (c >= 10 && c < 15) begin
        checks++;
        if (g !== 8'b1101_0000) begin
          failures++; $display("FAIL busywait_freeze cycle=%0d got=%b expected=11010000", c, g);
        end
      end
      if (g[0]) done_at = c;
      MULDIV_VALID_EX = 0;
    end
    checks++;
    if (done_at != 37) begin
      failures++; $display("FAIL busywait_div_done got=%0d expected=37", done_at);
    end
    clear_inputs();
  endtask

  task automatic test_branch_busywait();
    logic [7:0] g;
    do_reset();
    BRANCH_TAKEN_EX = 1; MEM_BUSYWAIT = 1;
    for (int k = 0; k < 3; k++) begin
      cycle(g);
      checks++;
      if (g !== 8'b1101_0000) begin
        failures++; $display("FAIL branch_in_busywait cycle=%0d got=%b expected=11010000", k, g);
      end
    end
    MEM_BUSYWAIT = 0;
    cycle(g);
    checks++;
    if (g !== 8'b0010_1000) begin
      failures++; $display("FAIL branch_after_busywait got=%b expected=00101000", g);
    end
    clear_inputs();
    cycle(g);
    checks++;
    if (PERF_FLUSH_CNT !== 16'd1) begin
      failures++; $display("FAIL branch_busywait_flush_cnt got=%0d expected=1", PERF_FLUSH_CNT);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] g;
    do_reset();
    MULDIV_VALID_EX = 1; MULDIV_IS_DIV_EX = 1;
    for (int k = 0; k < 7; k++) begin
      cycle(g);
      MULDIV_VALID_EX = 0;
    end
    #2;
    RESET_N = 0;
    md_left = 0; m_stall = '0; m_flush = '0;
    #1;
    checks++;
    if (dut_out() !== 8'h00 || PERF_STALL_CNT !== 0 || PERF_FLUSH_CNT !== 0) begin
      failures++;
      $display("FAIL async_reset got=%b/%0d/%0d expected=00000000/0/0",
               dut_out(), PERF_STALL_CNT, PERF_FLUSH_CNT);
    end
    cycle(g);
    #2;
    RESET_N = 1;
    cycle(g);
    MEM_READ_EN_IDEX = 1; REG_WRITE_ADDR_IDEX = 12; ADDR_2_ID = 12; USES_RS2_ID = 1;
    cycle(g);
    checks++;
    if (g !== 8'b1100_1000) begin
      failures++; $display("FAIL reset_returns_run got=%b expected=11001000", g);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [7:0] g;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      MEM_BUSYWAIT        = ($urandom_range(0, 5) == 0);
      MULDIV_VALID_EX     = ($urandom_range(0, 9) == 0);
      MULDIV_IS_DIV_EX    = ($urandom_range(0, 3) == 0);
      BRANCH_TAKEN_EX     = ($urandom_range(0, 3) == 0);
      MEM_READ_EN_IDEX    = $urandom_range(0, 1);
      REG_WRITE_ADDR_IDEX = 5'($urandom_range(0, 3));
      ADDR_1_ID           = 5'($urandom_range(0, 3));
      ADDR_2_ID           = 5'($urandom_range(0, 3));
      USES_RS1_ID         = $urandom_range(0, 1);
      USES_RS2_ID         = $urandom_range(0, 1);
      cycle(g);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch_load_use();
    test_muldiv(1'b1, DIV_LAT);
    test_muldiv(1'b0, MUL_LAT);
    test_busywait_div();
    test_branch_busywait();
    test_reset_mid_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
